uart_rx: RTL and testbench
==========================

# uart_rx

- Serial-to-parallel UART receive stage; sits directly upstream of the byte consumer.
- Samples the asynchronous `rx` line using oversampling ticks from the baud generator.
- Frames start / data / optional parity / stop bits and assembles data LSB-first by right shift.
- Presents each received word with a one-cycle done strobe plus framing and parity error flags.

## Interface
- `D_BIT`, 8, data bits per frame (5..9)
- `OS`, 16, ticks per bit (even, ≥4)
- `SB_TICK`, 16, ticks for stop bit(s): `OS`, `OS*3/2` or `2*OS`
- `PARITY_EN`, 0, 1 = a parity bit follows the data
- `PARITY_ODD`, 0, 1 = odd parity, 0 = even parity
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `s_tick`  in  1  oversampling strobe from the baud generator; one `clk` wide, `OS` per bit
- `rx`  in  1  asynchronous serial input; idles high
- `rx_dout`  out  `D_BIT`  last received word
- `rx_done_tick`  out  1  one-cycle strobe; `rx_dout` and flags are updated
- `frame_err`  out  1  stop bit sampled low in the last frame
- `parity_err`  out  1  parity mismatch in the last frame (0 when `PARITY_EN`=0)
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- Input sync: `rx` passes through 2 flops to give `rx_s`. Both flops reset to 1.
- Counters:
  - `s`: tick counter, width `$clog2(2*OS)`.
  - `n`: bit index, width `$clog2(D_BIT)`.
  - `b`: shift register, `D_BIT` wide.
  - `par_bad`: 1 bit.
- FSM states are IDLE, START, DATA, PARITY, STOP, BREAK. `s` and `n` advance only on `s_tick`.
- IDLE: when `rx_s`=0, go to START with `s`=0. This does not wait for `s_tick`.
- START: at `s`=`OS/2-1`, check `rx_s`.
  - `rx_s`=0: go to DATA with `s`=0, `n`=0.
  - `rx_s`=1: false start; return to IDLE with no outputs.
  - Otherwise `s`++.
- DATA: at `s`=`OS-1`:
  - Set `b` = {`rx_s`, `b[D_BIT-1:1]`} and `s`=0.
  - If `n`=`D_BIT-1`, go to PARITY when `PARITY_EN`=1, else STOP. Otherwise `n`++.
- PARITY: at `s`=`OS-1`, set `par_bad` = `rx_s` ^ (^`b`) ^ `PARITY_ODD`, then go to STOP with `s`=0.
- STOP: at `s`=`SB_TICK-1`, in one edge:
  - `rx_dout`←`b`, `rx_done_tick`←1.
  - `frame_err`←~`rx_s`, `parity_err`←`par_bad`.
  - Next state is IDLE if `rx_s`=1, else BREAK.
- BREAK: stay until `rx_s`=1, then go to IDLE. A line held low never starts a new frame.
- Outputs:
  - `rx_dout` and both error flags hold until the next `rx_done_tick`.
  - `rx_done_tick` fires even when a frame has errors.
  - `busy` is combinational from state.

## Timing
- Reset values: state IDLE, `s`, `n`, `b`, `par_bad` = 0.
- Output reset values: `rx_dout`=0, `rx_done_tick`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
- Start detect: 2 `clk` after the `rx` falling edge (synchronizer).
- Done latency, counted in `s_tick` after START is entered: `OS/2 + D_BIT*OS + PARITY_EN*OS + SB_TICK`.
  - Defaults give 152 ticks.
  - `rx_done_tick` is high for the single `clk` after the edge on which the final tick is counted.
- Sample points are mid-bit, `OS` ticks apart. The stop bit is sampled at its centre for `SB_TICK`=`OS`.
- Back-to-back frames: a start bit that follows the stop bit immediately is detected from IDLE with no lost cycle.
- `s_tick` in IDLE or BREAK is ignored.
- Glitch: a low pulse of fewer than `OS/2` ticks causes no done and no error.
- Reset mid-frame aborts immediately, with no done strobe. All outputs take their reset values.

## Structure
- Shared include `uart_defs.vh` holds:
  - FSM state encodings (3-bit localparams).
  - Default `OS`, `D_BIT`, `SB_TICK`.
  - The same defaults are used by the transmitter and the baud generator.
- One sub-module, `rx_sync`: 2-flop synchronizer, reset to 1.
- FSM, counters and shift register are inline, with separate state-register and next-state blocks.

## Test plan
- Default parameters, `s_tick` every 4 `clk`, send 0xA5 8N1 → `rx_dout`=0xA5, one-cycle `rx_done_tick` 152 ticks after start detect, `frame_err`=0, `busy` low afterwards.
- `rx` low for 5 ticks, then high → no `rx_done_tick`, `busy` returns to 0 and stays IDLE.
- 0x3C with stop bit low, then `rx` held low for 40 ticks → done with `rx_dout`=0x3C and `frame_err`=1, no second done while low; after `rx` goes high, 0x55 is received with `frame_err`=0.
- `PARITY_EN`=1, `PARITY_ODD`=0, data 0x07:
  - Parity bit 1 → `parity_err`=0.
  - Parity bit 0 → `parity_err`=1, `rx_dout`=0x07.
- 0x00 then 0xFF with no idle gap → two done strobes in order, correct data, no errors.
- Assert `rst` during data bit 4 of a frame → all outputs 0 at once, no done; after release, 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings and frame-format defaults
// common to the receiver, transmitter and baud generator.
package uart_rx_pkg;

    localparam int unsigned OS_DEF      = 16;
    localparam int unsigned D_BIT_DEF   = 8;
    localparam int unsigned SB_TICK_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle-high level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receive stage: oversampled start/data/parity/stop framing with
// LSB-first assembly, done strobe and framing/parity error flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned D_BIT      = D_BIT_DEF,
    parameter int unsigned OS         = OS_DEF,
    parameter int unsigned SB_TICK    = SB_TICK_DEF,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_tick,
    input  logic             rx,
    output logic [D_BIT-1:0] rx_dout,
    output logic             rx_done_tick,
    output logic             frame_err,
    output logic             parity_err,
    output logic             busy
);

    localparam int unsigned S_W = $clog2(2 * OS);
    localparam int unsigned N_W = $clog2(D_BIT);

    localparam logic [S_W-1:0] S_HALF = S_W'(OS / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OS - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(D_BIT - 1);

    logic             rx_s;
    state_t           state, state_n;
    logic [S_W-1:0]   s, s_n;
    logic [N_W-1:0]   n, n_n;
    logic [D_BIT-1:0] b, b_n;
    logic             par_bad, par_bad_n;
    logic [D_BIT-1:0] rx_dout_n;
    logic             rx_done_n, frame_err_n, parity_err_n;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign busy = (state != ST_IDLE);

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            par_bad      <= 1'b0;
            rx_dout      <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            b            <= b_n;
            par_bad      <= par_bad_n;
            rx_dout      <= rx_dout_n;
            rx_done_tick <= rx_done_n;
            frame_err    <= frame_err_n;
            parity_err   <= parity_err_n;
        end
    end

    // Next-state and output logic; counters only move on s_tick
    always_comb begin
        state_n      = state;
        s_n          = s;
        n_n          = n;
        b_n          = b;
        par_bad_n    = par_bad;
        rx_dout_n    = rx_dout;
        rx_done_n    = 1'b0;
        frame_err_n  = frame_err;
        parity_err_n = parity_err;

        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n = ST_START;
                    s_n     = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s == S_HALF) begin
                        if (!rx_s) begin
                            state_n = ST_DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        s_n = s + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        b_n = {rx_s, b[D_BIT-1:1]};
                        s_n = '0;
                        if (n == N_LAST) begin
                            state_n = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_n = n + N_W'(1);
                        end
                    end else begin
                        s_n = s + S_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        par_bad_n = rx_s ^ (^b) ^ (PARITY_ODD != 0);
                        state_n   = ST_STOP;
                        s_n       = '0;
                    end else begin
                        s_n = s + S_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s == S_STOP) begin
                        rx_dout_n    = b;
                        rx_done_n    = 1'b1;
                        frame_err_n  = ~rx_s;
                        parity_err_n = par_bad;
                        state_n      = rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        s_n = s + S_W'(1);
                    end
                end
            end
            ST_BREAK: begin
                // A line held low must return high before a new start is accepted
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: 8N1 and 8E1 instances driven
// from a shared tick generator with s_tick every 4 clk.
module tb_uart_rx;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx_a   = 1'b1;
    logic       rx_p   = 1'b1;

    logic [7:0] dout_a, dout_p;
    logic       done_a, done_p, fe_a, fe_p, pe_a, pe_p, busy_a, busy_p;

    int          checks = 0;
    int          errors = 0;
    int unsigned tick_cnt = 0;
    int          div = 0;

    int unsigned start_a = 0, start_p = 0;
    int          lat_a = 0, lat_p = 0;
    int          done_cnt_a = 0, done_cnt_p = 0;
    logic        done_prev_a = 1'b0, done_prev_p = 1'b0;
    logic        busy_prev_a = 1'b0, busy_prev_p = 1'b0;
    logic        dbl_a = 1'b0, dbl_p = 1'b0;
    int          c0;

    uart_rx dut_a (
        .clk (clk), .rst (rst), .s_tick (s_tick), .rx (rx_a),
        .rx_dout (dout_a), .rx_done_tick (done_a),
        .frame_err (fe_a), .parity_err (pe_a), .busy (busy_a)
    );

    uart_rx #(.PARITY_EN (1), .PARITY_ODD (0)) dut_p (
        .clk (clk), .rst (rst), .s_tick (s_tick), .rx (rx_p),
        .rx_dout (dout_p), .rx_done_tick (done_p),
        .frame_err (fe_p), .parity_err (pe_p), .busy (busy_p)
    );

    always #5 clk = ~clk;

    // s_tick changes on the falling edge so it is stable at every rising edge
    always @(negedge clk) begin
        div    = (div == 3) ? 0 : div + 1;
        s_tick = (div == 3);
    end

    always @(posedge clk) begin
        if (s_tick) tick_cnt <= tick_cnt + 1;
    end

    // Done counting, tick latency from START entry, and strobe-width watch
    always @(negedge clk) begin
        if (done_a) begin
            done_cnt_a = done_cnt_a + 1;
            lat_a      = int'(tick_cnt - start_a);
            if (done_prev_a) dbl_a = 1'b1;
        end
        if (busy_a && !busy_prev_a) start_a = tick_cnt;
        done_prev_a = done_a;
        busy_prev_a = busy_a;
        if (done_p) begin
            done_cnt_p = done_cnt_p + 1;
            lat_p      = int'(tick_cnt - start_p);
            if (done_prev_p) dbl_p = 1'b1;
        end
        if (busy_p && !busy_prev_p) start_p = tick_cnt;
        done_prev_p = done_p;
        busy_prev_p = busy_p;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            while (s_tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_bit(input int which, input logic v, input int k);
        if (which == 0) rx_a = v;
        else            rx_p = v;
        wait_ticks(k);
    endtask

    task automatic send_frame(input int which, input logic [7:0] data,
                              input bit use_par, input logic par_v, input logic stop_v);
        send_bit(which, 1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(which, data[i], 16);
        if (use_par) send_bit(which, par_v, 16);
        send_bit(which, stop_v, 16);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout_a), 32'h00);
        check("rst_done", 32'(done_a), 32'h0);
        check("rst_fe",   32'(fe_a),   32'h0);
        check("rst_pe",   32'(pe_a),   32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_busy_p", 32'(busy_p), 32'h0);
        rst = 1'b1;
        wait_ticks(4);

        // 0xA5 8N1
        c0 = done_cnt_a;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_ticks(2);
        check("a5_count", 32'(done_cnt_a - c0), 32'd1);
        check("a5_dout",  32'(dout_a), 32'hA5);
        check("a5_fe",    32'(fe_a),   32'h0);
        check("a5_pe",    32'(pe_a),   32'h0);
        check("a5_lat",   32'(lat_a),  32'd152);
        check("a5_busy",  32'(busy_a), 32'h0);
        check("a5_done_low", 32'(done_a), 32'h0);

        // Short low glitch is a false start
        c0 = done_cnt_a;
        send_bit(0, 1'b0, 5);
        send_bit(0, 1'b1, 12);
        check("glitch_count", 32'(done_cnt_a - c0), 32'd0);
        check("glitch_busy",  32'(busy_a), 32'h0);
        check("glitch_dout",  32'(dout_a), 32'hA5);

        // Framing error followed by a held-low break, then recovery
        c0 = done_cnt_a;
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        send_bit(0, 1'b0, 40);
        check("brk_count", 32'(done_cnt_a - c0), 32'd1);
        check("brk_dout",  32'(dout_a), 32'h3C);
        check("brk_fe",    32'(fe_a),   32'h1);
        check("brk_busy",  32'(busy_a), 32'h1);
        send_bit(0, 1'b1, 4);
        check("brk_idle",  32'(busy_a), 32'h0);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        wait_ticks(2);
        check("rec_count", 32'(done_cnt_a - c0), 32'd2);
        check("rec_dout",  32'(dout_a), 32'h55);
        check("rec_fe",    32'(fe_a),   32'h0);

        // Even parity, 0x07 has three ones
        c0 = done_cnt_p;
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        wait_ticks(2);
        check("par_ok_count", 32'(done_cnt_p - c0), 32'd1);
        check("par_ok_dout",  32'(dout_p), 32'h07);
        check("par_ok_pe",    32'(pe_p),   32'h0);
        check("par_ok_fe",    32'(fe_p),   32'h0);
        check("par_ok_lat",   32'(lat_p),  32'd168);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        wait_ticks(2);
        check("par_bad_count", 32'(done_cnt_p - c0), 32'd2);
        check("par_bad_dout",  32'(dout_p), 32'h07);
        check("par_bad_pe",    32'(pe_p),   32'h1);
        check("par_dbl",       32'(dbl_p),  32'h0);

        // Back-to-back frames with no idle gap
        c0 = done_cnt_a;
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("b2b_first_count", 32'(done_cnt_a - c0), 32'd1);
        check("b2b_first_dout",  32'(dout_a), 32'h00);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        wait_ticks(2);
        check("b2b_count", 32'(done_cnt_a - c0), 32'd2);
        check("b2b_dout",  32'(dout_a), 32'hFF);
        check("b2b_fe",    32'(fe_a),   32'h0);
        check("b2b_dbl",   32'(dbl_a),  32'h0);

        // Reset in the middle of data bit 4
        c0 = done_cnt_a;
        send_bit(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 16);
        send_bit(0, 1'b0, 8);
        rst = 1'b0;
        #1;
        check("mid_rst_dout", 32'(dout_a), 32'h00);
        check("mid_rst_done", 32'(done_a), 32'h0);
        check("mid_rst_fe",   32'(fe_a),   32'h0);
        check("mid_rst_busy", 32'(busy_a), 32'h0);
        check("mid_rst_pe_p", 32'(pe_p),   32'h0);
        rx_a = 1'b1;
        wait_ticks(2);
        rst = 1'b1;
        wait_ticks(4);
        check("mid_rst_nodone", 32'(done_cnt_a - c0), 32'd0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        wait_ticks(2);
        check("post_rst_count", 32'(done_cnt_a - c0), 32'd1);
        check("post_rst_dout",  32'(dout_a), 32'h81);
        check("post_rst_fe",    32'(fe_a),   32'h0);
        check("post_rst_busy",  32'(busy_a), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
